// File: rtl/grid_mover_pkg.sv
// Shared direction codes, FSM encodings and helpers for the grid mover.
package grid_mover_pkg;

  localparam int unsigned DIR_W = 3;

  typedef enum logic [DIR_W-1:0] {
    DIR_RIGHT = 3'd0,
    DIR_UP    = 3'd1,
    DIR_LEFT  = 3'd2,
    DIR_DOWN  = 3'd3,
    DIR_WAIT  = 3'd4
  } dir_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD1  = 3'd1,
    ST_CK1  = 3'd2,
    ST_RD2  = 3'd3,
    ST_CK2  = 3'd4
  } state_e;

  // Codes 0..4 are commands; 5..7 are ignored by the pending-turn register.
  function automatic logic dir_is_cmd(input logic [DIR_W-1:0] d);
    return d <= DIR_W'(4);
  endfunction

endpackage

// File: rtl/grid_mover_if.sv
// Maze ROM query port: read strobe + tile address out, blocked answer back one cycle later.
interface grid_mover_if #(
  parameter int unsigned X_W = 8,
  parameter int unsigned Y_W = 7
);
  logic           wall_rd;
  logic [X_W-1:0] wall_x;
  logic [Y_W-1:0] wall_y;
  logic           wall_blocked;

  modport master (output wall_rd, output wall_x, output wall_y, input wall_blocked);
  modport slave  (input wall_rd, input wall_x, input wall_y, output wall_blocked);
endinterface

// File: rtl/grid_mover_step.sv
// Neighbour-tile calculator: (x, y, dir) -> next tile, with edge wrap or off-grid flag.
module grid_mover_step
  import grid_mover_pkg::*;
#(
  parameter int unsigned GRID_W = 27,
  parameter int unsigned GRID_H = 24,
  parameter int unsigned X_W    = 8,
  parameter int unsigned Y_W    = 7,
  parameter int unsigned WRAP   = 1
) (
  input  logic [X_W-1:0] i_x,
  input  logic [Y_W-1:0] i_y,
  input  dir_e           i_dir,
  output logic [X_W-1:0] o_nx_c,
  output logic [Y_W-1:0] o_ny_c,
  output logic           o_off_grid_c
);

  localparam logic [X_W-1:0] X_MAX = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(GRID_H - 1);

  // Off-grid targets keep the current tile so no out-of-range value ever propagates.
  always_comb begin
    o_nx_c       = i_x;
    o_ny_c       = i_y;
    o_off_grid_c = 1'b0;
    case (i_dir)
      DIR_RIGHT: begin
        if (i_x == X_MAX) begin
          if (WRAP != 0) o_nx_c = '0;
          else           o_off_grid_c = 1'b1;
        end else begin
          o_nx_c = i_x + X_W'(1);
        end
      end
      DIR_LEFT: begin
        if (i_x == '0) begin
          if (WRAP != 0) o_nx_c = X_MAX;
          else           o_off_grid_c = 1'b1;
        end else begin
          o_nx_c = i_x - X_W'(1);
        end
      end
      DIR_UP: begin
        if (i_y == '0) begin
          if (WRAP != 0) o_ny_c = Y_MAX;
          else           o_off_grid_c = 1'b1;
        end else begin
          o_ny_c = i_y - Y_W'(1);
        end
      end
      DIR_DOWN: begin
        if (i_y == Y_MAX) begin
          if (WRAP != 0) o_ny_c = '0;
          else           o_off_grid_c = 1'b1;
        end else begin
          o_ny_c = i_y + Y_W'(1);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/grid_mover.sv
// Sprite tile mover: divided step rate, queued turn request, wall checks via maze ROM.
module grid_mover
  import grid_mover_pkg::*;
#(
  parameter int unsigned GRID_W   = 27,
  parameter int unsigned GRID_H   = 24,
  parameter int unsigned X_W      = 8,
  parameter int unsigned Y_W      = 7,
  parameter int unsigned START_X  = 0,
  parameter int unsigned START_Y  = 0,
  parameter int unsigned STEP_DIV = 4,
  parameter int unsigned WRAP     = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_step_tick,
  input  logic [DIR_W-1:0] i_dir_in,
  grid_mover_if.master     rom,
  output logic [X_W-1:0]   o_x_out,
  output logic [Y_W-1:0]   o_y_out,
  output logic [DIR_W-1:0] o_heading,
  output logic             o_moved,
  output logic             o_busy
);

  localparam int unsigned DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  state_e         r_state, w_state_nxt;
  logic [X_W-1:0] r_x, w_x_nxt, r_tx, w_tx_nxt, r_wall_x, w_wall_x_nxt, w_nx;
  logic [Y_W-1:0] r_y, w_y_nxt, r_ty, w_ty_nxt, r_wall_y, w_wall_y_nxt, w_ny;
  dir_e           r_heading, w_heading_nxt, r_pending, r_tdir, w_tdir_nxt, w_step_dir;
  logic           r_toff, w_toff_nxt, w_off;
  logic           r_wall_rd, w_wall_rd_nxt;
  logic           r_moved, w_moved_nxt;
  logic           r_busy;
  logic           r_step_pend, w_consume, w_wrap, w_blocked;
  logic [DIV_W-1:0] r_div;

  // Queries from IDLE use the pending turn when it differs; every other query follows heading.
  assign w_step_dir = (r_state == ST_IDLE && r_pending != r_heading) ? r_pending : r_heading;

  grid_mover_step #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H),
    .X_W    (X_W),
    .Y_W    (Y_W),
    .WRAP   (WRAP)
  ) u_step (
    .i_x          (r_x),
    .i_y          (r_y),
    .i_dir        (w_step_dir),
    .o_nx_c       (w_nx),
    .o_ny_c       (w_ny),
    .o_off_grid_c (w_off)
  );

  assign w_wrap    = i_step_tick && (r_div == DIV_W'(STEP_DIV - 1));
  assign w_blocked = r_toff || rom.wall_blocked;

  // Step-rate divider and single step-request flag; a new wrap wins over a same-cycle consume.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_div       <= '0;
      r_step_pend <= 1'b0;
    end else begin
      if (i_step_tick) r_div <= w_wrap ? '0 : r_div + DIV_W'(1);
      if (w_wrap)         r_step_pend <= 1'b1;
      else if (w_consume) r_step_pend <= 1'b0;
    end
  end

  // Pending turn tracks the decoder every cycle, ignoring codes 5..7.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pending <= DIR_WAIT;
    end else if (dir_is_cmd(i_dir_in)) begin
      r_pending <= dir_e'(i_dir_in);
    end
  end

  // Next-state and next-output logic for the query sequence.
  always_comb begin
    w_state_nxt   = r_state;
    w_x_nxt       = r_x;
    w_y_nxt       = r_y;
    w_heading_nxt = r_heading;
    w_tx_nxt      = r_tx;
    w_ty_nxt      = r_ty;
    w_tdir_nxt    = r_tdir;
    w_toff_nxt    = r_toff;
    w_wall_x_nxt  = r_wall_x;
    w_wall_y_nxt  = r_wall_y;
    w_wall_rd_nxt = 1'b0;
    w_moved_nxt   = 1'b0;
    w_consume     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_step_pend) begin
          w_consume = 1'b1;
          if (r_pending == DIR_WAIT) begin
            w_heading_nxt = DIR_WAIT;
          end else begin
            w_tx_nxt      = w_nx;
            w_ty_nxt      = w_ny;
            w_tdir_nxt    = w_step_dir;
            w_toff_nxt    = w_off;
            w_wall_x_nxt  = w_nx;
            w_wall_y_nxt  = w_ny;
            w_wall_rd_nxt = !w_off;
            w_state_nxt   = (r_pending != r_heading) ? ST_RD1 : ST_RD2;
          end
        end
      end
      ST_RD1: w_state_nxt = ST_CK1;
      ST_CK1: begin
        if (!w_blocked) begin
          w_x_nxt       = r_tx;
          w_y_nxt       = r_ty;
          w_heading_nxt = r_tdir;
          w_moved_nxt   = 1'b1;
          w_state_nxt   = ST_IDLE;
        end else if (r_heading == DIR_WAIT) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_tx_nxt      = w_nx;
          w_ty_nxt      = w_ny;
          w_tdir_nxt    = r_heading;
          w_toff_nxt    = w_off;
          w_wall_x_nxt  = w_nx;
          w_wall_y_nxt  = w_ny;
          w_wall_rd_nxt = !w_off;
          w_state_nxt   = ST_RD2;
        end
      end
      ST_RD2: w_state_nxt = ST_CK2;
      ST_CK2: begin
        if (!w_blocked) begin
          w_x_nxt     = r_tx;
          w_y_nxt     = r_ty;
          w_moved_nxt = 1'b1;
        end else begin
          w_heading_nxt = DIR_WAIT;
        end
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, position and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_x       <= X_W'(START_X);
      r_y       <= Y_W'(START_Y);
      r_heading <= DIR_WAIT;
      r_tx      <= '0;
      r_ty      <= '0;
      r_tdir    <= DIR_WAIT;
      r_toff    <= 1'b0;
      r_wall_x  <= '0;
      r_wall_y  <= '0;
      r_wall_rd <= 1'b0;
      r_moved   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_x       <= w_x_nxt;
      r_y       <= w_y_nxt;
      r_heading <= w_heading_nxt;
      r_tx      <= w_tx_nxt;
      r_ty      <= w_ty_nxt;
      r_tdir    <= w_tdir_nxt;
      r_toff    <= w_toff_nxt;
      r_wall_x  <= w_wall_x_nxt;
      r_wall_y  <= w_wall_y_nxt;
      r_wall_rd <= w_wall_rd_nxt;
      r_moved   <= w_moved_nxt;
      r_busy    <= (w_state_nxt != ST_IDLE);
    end
  end

  assign rom.wall_rd = r_wall_rd;
  assign rom.wall_x  = r_wall_x;
  assign rom.wall_y  = r_wall_y;
  assign o_x_out     = r_x;
  assign o_y_out     = r_y;
  assign o_heading   = r_heading;
  assign o_moved     = r_moved;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_grid_mover.sv
// Bench for grid_mover: WRAP=1 and WRAP=0 instances driven in lockstep against a step-level model.
module tb_grid_mover;
  import grid_mover_pkg::*;

  localparam int          GW   = 27;
  localparam int          GH   = 24;
  localparam int unsigned XW   = 8;
  localparam int unsigned YW   = 7;
  localparam int          SDIV = 4;

  logic           clock = 1'b0;
  logic           reset;
  logic           tick;
  logic [2:0]     dir;
  logic [XW-1:0]  xa, xb;
  logic [YW-1:0]  ya, yb;
  logic [2:0]     ha, hb;
  logic           mva, mvb, bsa, bsb;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  bit maze [GW][GH];
  int mx[2], my[2], mh[2], mp[2];
  int mv_cnt[2], rd_cnt[2], bz_cnt[2], mv_cyc[2];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  grid_mover_if #(.X_W(XW), .Y_W(YW)) rom_a ();
  grid_mover_if #(.X_W(XW), .Y_W(YW)) rom_b ();

  grid_mover #(.GRID_W(GW), .GRID_H(GH), .X_W(XW), .Y_W(YW), .START_X(0), .START_Y(0),
               .STEP_DIV(SDIV), .WRAP(1)) dut_a (
    .clock(clock), .reset(reset), .i_step_tick(tick), .i_dir_in(dir), .rom(rom_a),
    .o_x_out(xa), .o_y_out(ya), .o_heading(ha), .o_moved(mva), .o_busy(bsa));

  grid_mover #(.GRID_W(GW), .GRID_H(GH), .X_W(XW), .Y_W(YW), .START_X(0), .START_Y(0),
               .STEP_DIV(SDIV), .WRAP(0)) dut_b (
    .clock(clock), .reset(reset), .i_step_tick(tick), .i_dir_in(dir), .rom(rom_b),
    .o_x_out(xb), .o_y_out(yb), .o_heading(hb), .o_moved(mvb), .o_busy(bsb));

  function automatic bit maze_at(input logic [XW-1:0] x, input logic [YW-1:0] y);
    if (int'(x) < GW && int'(y) < GH) return maze[int'(x)][int'(y)];
    return 1'b1;
  endfunction

  // Maze ROMs: answer one cycle after a read, random garbage otherwise.
  always @(posedge clock) begin
    rom_a.wall_blocked <= rom_a.wall_rd ? maze_at(rom_a.wall_x, rom_a.wall_y) : 1'($urandom);
    rom_b.wall_blocked <= rom_b.wall_rd ? maze_at(rom_b.wall_x, rom_b.wall_y) : 1'($urandom);
  end

  // Running event counters sampled mid-cycle.
  always @(negedge clock) begin
    if (mva === 1'b1) begin mv_cnt[0] <= mv_cnt[0] + 1; mv_cyc[0] <= cyc; end
    if (mvb === 1'b1) begin mv_cnt[1] <= mv_cnt[1] + 1; mv_cyc[1] <= cyc; end
    if (rom_a.wall_rd === 1'b1) rd_cnt[0] <= rd_cnt[0] + 1;
    if (rom_b.wall_rd === 1'b1) rd_cnt[1] <= rd_cnt[1] + 1;
    if (bsa === 1'b1) bz_cnt[0] <= bz_cnt[0] + 1;
    if (bsb === 1'b1) bz_cnt[1] <= bz_cnt[1] + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Neighbour tile on the grid; off-grid only when edges do not wrap.
  function automatic void mnext(input int x, input int y, input int d, input int w,
                                output int nx, output int ny, output bit off);
    nx = x; ny = y; off = 1'b0;
    case (d)
      0: nx = x + 1;
      1: ny = y - 1;
      2: nx = x - 1;
      3: ny = y + 1;
      default: ;
    endcase
    if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
      if (w != 0) begin
        nx = (nx + GW) % GW;
        ny = (ny + GH) % GH;
      end else begin
        off = 1'b1; nx = x; ny = y;
      end
    end
  endfunction

  // One attempted move: try the queued turn, fall back to current heading, else stop.
  function automatic void model_step(input int i, output int e_mv, output int e_rd, output int e_bz);
    int nx, ny, w;
    bit off;
    w = (i == 0) ? 1 : 0;
    e_mv = 0; e_rd = 0; e_bz = 0;
    if (mp[i] == 4) begin mh[i] = 4; return; end
    if (mp[i] != mh[i]) begin
      mnext(mx[i], my[i], mp[i], w, nx, ny, off);
      e_bz = 2;
      if (!off) e_rd++;
      if (!off && !maze[nx][ny]) begin
        mx[i] = nx; my[i] = ny; mh[i] = mp[i]; e_mv = 1;
        return;
      end
      if (mh[i] == 4) return;
    end
    mnext(mx[i], my[i], mh[i], w, nx, ny, off);
    e_bz += 2;
    if (!off) e_rd++;
    if (!off && !maze[nx][ny]) begin
      mx[i] = nx; my[i] = ny; e_mv = 1;
    end else begin
      mh[i] = 4;
    end
  endfunction

  function automatic logic [31:0] obs_x(input int i);  return (i == 0) ? 32'(xa) : 32'(xb); endfunction
  function automatic logic [31:0] obs_y(input int i);  return (i == 0) ? 32'(ya) : 32'(yb); endfunction
  function automatic logic [31:0] obs_h(input int i);  return (i == 0) ? 32'(ha) : 32'(hb); endfunction
  function automatic logic [31:0] obs_bs(input int i); return (i == 0) ? 32'(bsa) : 32'(bsb); endfunction
  function automatic logic [31:0] obs_mv(input int i); return (i == 0) ? 32'(mva) : 32'(mvb); endfunction
  function automatic logic [31:0] obs_rd(input int i);
    return (i == 0) ? 32'(rom_a.wall_rd) : 32'(rom_b.wall_rd);
  endfunction

  task automatic set_pending(input logic [2:0] d);
    if (d <= 3'd4) for (int i = 0; i < 2; i++) mp[i] = int'(d);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1; tick = 1'b1;
    @(negedge clock);
    reset = 1'b0; tick = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s.%0d x", tag, i), obs_x(i), 32'd0);
      chk($sformatf("%s.%0d y", tag, i), obs_y(i), 32'd0);
      chk($sformatf("%s.%0d heading", tag, i), obs_h(i), 32'd4);
      chk($sformatf("%s.%0d busy", tag, i), obs_bs(i), 32'd0);
      chk($sformatf("%s.%0d moved", tag, i), obs_mv(i), 32'd0);
      chk($sformatf("%s.%0d wall_rd", tag, i), obs_rd(i), 32'd0);
      mx[i] = 0; my[i] = 0; mh[i] = 4;
      mp[i] = (dir <= 3'd4) ? int'(dir) : 4;
    end
    chk({tag, " wall_x"}, 32'(rom_a.wall_x), 32'd0);
    chk({tag, " wall_y"}, 32'(rom_a.wall_y), 32'd0);
  endtask

  task automatic do_step(input string tag, input logic [2:0] d, input bit chg, input logic [2:0] d2);
    int s_mv[2], s_rd[2], s_bz[2];
    int e_mv[2], e_rd[2], e_bz[2];
    int t0;
    dir = d;
    set_pending(d);
    for (int i = 0; i < 2; i++) begin
      s_mv[i] = mv_cnt[i]; s_rd[i] = rd_cnt[i]; s_bz[i] = bz_cnt[i];
    end
    for (int k = 0; k < SDIV; k++) begin
      tick = 1'b1;
      @(negedge clock);
    end
    tick = 1'b0;
    t0 = cyc;
    for (int i = 0; i < 2; i++) model_step(i, e_mv[i], e_rd[i], e_bz[i]);
    @(negedge clock);
    if (chg) begin
      dir = d2;
      set_pending(d2);
    end
    while (cyc < t0 + 8) @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s.%0d x", tag, i), obs_x(i), 32'(mx[i]));
      chk($sformatf("%s.%0d y", tag, i), obs_y(i), 32'(my[i]));
      chk($sformatf("%s.%0d heading", tag, i), obs_h(i), 32'(mh[i]));
      chk($sformatf("%s.%0d moved_cnt", tag, i), 32'(mv_cnt[i] - s_mv[i]), 32'(e_mv[i]));
      chk($sformatf("%s.%0d rd_cnt", tag, i), 32'(rd_cnt[i] - s_rd[i]), 32'(e_rd[i]));
      chk($sformatf("%s.%0d busy_cycles", tag, i), 32'(bz_cnt[i] - s_bz[i]), 32'(e_bz[i]));
      chk($sformatf("%s.%0d busy_end", tag, i), obs_bs(i), 32'd0);
      if (e_mv[i] != 0)
        chk($sformatf("%s.%0d latency", tag, i), 32'(mv_cyc[i] - t0), 32'(e_bz[i] + 1));
    end
  endtask

  task automatic clear_maze();
    for (int x = 0; x < GW; x++)
      for (int y = 0; y < GH; y++) maze[x][y] = 1'b0;
  endtask

  initial begin
    int t0;
    int s_mv[2];
    reset = 1'b1; tick = 1'b0; dir = 3'd0;
    clear_maze();
    @(negedge clock);
    do_reset("rst0");

    // First move after reset, then run right across the edge.
    do_step("t1", 3'd0, 1'b0, 3'd0);
    for (int s = 0; s < 27; s++) do_step($sformatf("t2_%0d", s), 3'd0, 1'b0, 3'd0);

    // Queued turn blocked, continue straight; turn taken once the cell is free.
    dir = 3'd3;
    do_reset("rst1");
    for (int s = 0; s < 3; s++) do_step("t3dn", 3'd3, 1'b0, 3'd0);
    do_step("t3r0", 3'd0, 1'b0, 3'd0);
    do_step("t3r1", 3'd0, 1'b0, 3'd0);
    maze[2][2] = 1'b1;
    do_step("t3blk", 3'd1, 1'b0, 3'd0);
    do_step("t3turn", 3'd6, 1'b0, 3'd0);

    // Both requested and current targets blocked: stop.
    maze[3][1] = 1'b1;
    do_step("t4", 3'd2, 1'b0, 3'd0);

    // Ignored codes keep the queued turn; WAIT stops without a query.
    maze[2][2] = 1'b0;
    do_step("t5a", 3'd6, 1'b0, 3'd0);
    do_step("t5b", 3'd4, 1'b0, 3'd0);

    // Randomised maze and commands, with direction changes mid-query.
    for (int r = 0; r < 150; r++) begin
      if (r % 25 == 0)
        for (int x = 0; x < GW; x++)
          for (int y = 0; y < GH; y++) maze[x][y] = ($urandom_range(0, 99) < 30);
      do_step($sformatf("rnd%0d", r), 3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
              3'($urandom_range(0, 7)));
    end

    // Reset during the wall check aborts the move.
    clear_maze();
    dir = 3'd3;
    do_reset("rst2");
    do_step("t6pre0", 3'd3, 1'b0, 3'd0);
    do_step("t6pre1", 3'd3, 1'b0, 3'd0);
    dir = 3'd0;
    for (int i = 0; i < 2; i++) s_mv[i] = mv_cnt[i];
    for (int k = 0; k < SDIV; k++) begin
      tick = 1'b1;
      @(negedge clock);
    end
    tick = 1'b0;
    t0 = cyc;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("t6.%0d x", i), obs_x(i), 32'd0);
      chk($sformatf("t6.%0d y", i), obs_y(i), 32'd0);
      chk($sformatf("t6.%0d heading", i), obs_h(i), 32'd4);
      chk($sformatf("t6.%0d busy", i), obs_bs(i), 32'd0);
      chk($sformatf("t6.%0d wall_rd", i), obs_rd(i), 32'd0);
      chk($sformatf("t6.%0d moved", i), obs_mv(i), 32'd0);
    end
    chk("t6 when", 32'(cyc - t0), 32'd3);
    reset = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("t6.%0d no_pulse", i), 32'(mv_cnt[i] - s_mv[i]), 32'd0);
      mx[i] = 0; my[i] = 0; mh[i] = 4; mp[i] = 0;
    end
    do_step("t6post", 3'd0, 1'b0, 3'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 2ms");
    $fatal(1, "watchdog");
  end

endmodule
